// File: rtl/ber_pkg.sv
// Shared definitions for the BER error counter slice.
//   ber_state_t : window FSM state (IDLE, RUN, FLUSH, DONE)
//   popcnt_w()  : width needed to hold a popcount of a w-bit word
//   DEF_*       : default widths and reset values used by the counter
package ber_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } ber_state_t;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_WIN_W  = 16;
  localparam int unsigned DEF_CNT_W  = 24;

  localparam ber_state_t RESET_STATE = IDLE;

  // Bits needed to represent the values 0..w inclusive.
  function automatic int unsigned popcnt_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/ber_popcount.sv
// Combinational population count of a DATA_W-bit word.
//   din   : word to count
//   count : number of set bits in din
// Implemented as a balanced adder tree over a power-of-two number of
// leaves; leaves beyond DATA_W are tied to zero.
module ber_popcount
  import ber_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0]           din,
  output logic [popcnt_w(DATA_W)-1:0] count
);

  localparam int unsigned OUT_W = popcnt_w(DATA_W);
  localparam int unsigned LVLS  = (DATA_W > 1) ? $clog2(DATA_W) : 0;
  localparam int unsigned N     = 1 << LVLS;
  localparam int unsigned NODES = 2 * N - 1;

  // Heap-ordered tree: node k has children 2k+1 and 2k+2, leaves start at N-1.
  // Every partial sum is bounded by DATA_W, so OUT_W bits suffice at all levels.
  logic [OUT_W-1:0] node [NODES];

  always_comb begin
    for (int unsigned k = 0; k < NODES; k++) begin
      node[k] = '0;
    end
    for (int unsigned i = 0; i < DATA_W; i++) begin
      node[N - 1 + i] = OUT_W'(din[i]);
    end
    for (int unsigned k = N - 1; k > 0; k--) begin
      node[k - 1] = node[2 * k - 1] + node[2 * k];
    end
  end

  assign count = node[0];

endmodule

// File: rtl/ber_error_counter.sv
// Windowed bit-error counter for the BER tester receive path.
// Each accepted word is compared (A ^ B) and its error popcount is
// accumulated over a programmable window of win_len words.
//   clk, rst  : clock, synchronous active-high reset
//   start     : open a window of win_len words (accepted in IDLE only)
//   abort     : close the window early, no done pulse
//   win_len   : words per window, latched on accepted start
//   valid,A,B : compared word pair (A expected, B received)
//   error     : registered A^B of last accepted word
//   err_bits  : registered popcount of error
//   busy      : window open or pipeline flushing
//   done      : one-cycle pulse when final results are valid
//   bit_errs  : accumulated bit errors (saturating)
//   words     : words compared in the window
//   sat       : sticky, bit_errs saturated this window
// Pipeline: stage 1 registers error/err_bits/words, stage 2 adds err_bits
// into bit_errs one cycle later.
module ber_error_counter
  import ber_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned WIN_W  = DEF_WIN_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [WIN_W-1:0]            win_len,
  input  logic                        valid,
  input  logic [DATA_W-1:0]           A,
  input  logic [DATA_W-1:0]           B,
  output logic [DATA_W-1:0]           error,
  output logic [popcnt_w(DATA_W)-1:0] err_bits,
  output logic                        busy,
  output logic                        done,
  output logic [CNT_W-1:0]            bit_errs,
  output logic [WIN_W-1:0]            words,
  output logic                        sat
);

  localparam int unsigned PC_W  = popcnt_w(DATA_W);
  localparam int unsigned SUM_W = CNT_W + 1;

  ber_state_t       state_q, state_d;
  logic [WIN_W-1:0] win_len_q;
  logic [WIN_W-1:0] last_idx;
  logic [PC_W-1:0]  pc;
  logic [SUM_W-1:0] acc_sum;
  logic             add_pend;
  logic             accept_start;
  logic             take_word;
  logic             last_word;

  ber_popcount #(
    .DATA_W (DATA_W)
  ) u_popcount (
    .din   (A ^ B),
    .count (pc)
  );

  // win_len_q is never zero in RUN, so last_idx cannot underflow there.
  assign last_idx     = win_len_q - WIN_W'(1);
  assign accept_start = (state_q == IDLE) && start && (win_len != '0);
  // abort beats a coincident valid word.
  assign take_word    = (state_q == RUN) && valid && !abort;
  assign last_word    = take_word && (words == last_idx);

  // One extra bit catches overflow for saturation.
  assign acc_sum      = {1'b0, bit_errs} + SUM_W'(err_bits);

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept_start) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (abort)          state_d = IDLE;
        else if (last_word) state_d = FLUSH;
      end
      FLUSH: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Window length is captured only on an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_len_q <= '0;
    end else if (accept_start) begin
      win_len_q <= win_len;
    end
  end

  // Stage 1: compare, popcount, word count.
  always_ff @(posedge clk) begin
    if (rst) begin
      error    <= '0;
      err_bits <= '0;
      words    <= '0;
      add_pend <= 1'b0;
    end else if (accept_start) begin
      error    <= '0;
      err_bits <= '0;
      words    <= '0;
      add_pend <= 1'b0;
    end else begin
      add_pend <= take_word;
      if (take_word) begin
        error    <= A ^ B;
        err_bits <= pc;
        words    <= words + WIN_W'(1);
      end
    end
  end

  // Stage 2: saturating accumulation. add_pend keeps the last word of an
  // aborted or finished window flowing through after the FSM has moved on.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_errs <= '0;
      sat      <= 1'b0;
    end else if (accept_start) begin
      bit_errs <= '0;
      sat      <= 1'b0;
    end else if (add_pend) begin
      if (acc_sum[CNT_W]) begin
        bit_errs <= '1;
        sat      <= 1'b1;
      end else begin
        bit_errs <= acc_sum[CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_ber_error_counter.sv
module tb_ber_error_counter;

  localparam int unsigned DW  = 8;
  localparam int unsigned WW  = 16;
  localparam int unsigned CW  = 24;
  localparam int unsigned CWS = 4;
  localparam int unsigned PW  = 4;
  localparam int unsigned SMAX = (1 << CWS) - 1;

  logic          clk = 1'b0;
  logic          rst, start, abort, valid;
  logic [WW-1:0] win_len;
  logic [DW-1:0] A, B;

  logic [DW-1:0]  error,    s_error;
  logic [PW-1:0]  err_bits, s_err_bits;
  logic           busy,     s_busy;
  logic           done,     s_done;
  logic [CW-1:0]  bit_errs;
  logic [CWS-1:0] s_bit_errs;
  logic [WW-1:0]  words,    s_words;
  logic           sat,      s_sat;

  ber_error_counter #(.DATA_W(DW), .WIN_W(WW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .win_len(win_len),
    .valid(valid), .A(A), .B(B), .error(error), .err_bits(err_bits),
    .busy(busy), .done(done), .bit_errs(bit_errs), .words(words), .sat(sat)
  );

  // Narrow accumulator copy, same stimulus, to exercise saturation.
  ber_error_counter #(.DATA_W(DW), .WIN_W(WW), .CNT_W(CWS)) dut_s (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .win_len(win_len),
    .valid(valid), .A(A), .B(B), .error(s_error), .err_bits(s_err_bits),
    .busy(s_busy), .done(s_done), .bit_errs(s_bit_errs), .words(s_words), .sat(s_sat)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Transaction-level reference: state of the current window.
  int unsigned   m_words;
  longint unsigned m_bits;
  logic [DW-1:0] m_err;
  int unsigned   m_eb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_words = 0;
    m_bits  = 0;
    m_err   = '0;
    m_eb    = 0;
  endtask

  task automatic model_word(input logic [DW-1:0] a, input logic [DW-1:0] b);
    m_err   = a ^ b;
    m_eb    = $countones(a ^ b);
    m_words = m_words + 1;
    m_bits  = m_bits + m_eb;
  endtask

  task automatic check_results(input string tag);
    chk({tag, ".words"},      32'(words),      32'(m_words));
    chk({tag, ".s_words"},    32'(s_words),    32'(m_words));
    chk({tag, ".bit_errs"},   32'(bit_errs),   32'(m_bits));
    chk({tag, ".sat"},        32'(sat),        32'(m_bits > ((1 << CW) - 1)));
    chk({tag, ".s_bit_errs"}, 32'(s_bit_errs), 32'((m_bits > SMAX) ? SMAX : m_bits));
    chk({tag, ".s_sat"},      32'(s_sat),      32'(m_bits > SMAX));
  endtask

  task automatic check_stage1(input string tag);
    chk({tag, ".error"},    32'(error),      32'(m_err));
    chk({tag, ".err_bits"}, 32'(err_bits),   32'(m_eb));
    chk({tag, ".s_error"},  32'(s_error),    32'(m_err));
  endtask

  task automatic open_window(input string tag, input logic [WW-1:0] len);
    start   = 1'b1;
    win_len = len;
    valid   = 1'($urandom);
    A       = DW'($urandom);
    B       = DW'($urandom);
    step();
    start = 1'b0;
    valid = 1'b0;
    model_clear();
    chk({tag, ".busy"}, 32'(busy), 32'(1));
    chk({tag, ".done"}, 32'(done), 32'(0));
    check_stage1(tag);
    check_results(tag);
  endtask

  task automatic send_word(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b);
    repeat ($urandom_range(0, 2)) begin
      valid = 1'b0;
      A     = DW'($urandom);
      B     = DW'($urandom);
      step();
      chk({tag, ".hold_error"}, 32'(error), 32'(m_err));
    end
    valid = 1'b1;
    A     = a;
    B     = b;
    step();
    valid = 1'b0;
    model_word(a, b);
    check_stage1(tag);
    chk({tag, ".words1"}, 32'(words), 32'(m_words));
  endtask

  // Call right after the last word: FLUSH now, DONE next cycle.
  task automatic finish_window(input string tag, input bit start_in_done);
    chk({tag, ".flush_busy"}, 32'(busy), 32'(1));
    chk({tag, ".flush_done"}, 32'(done), 32'(0));
    step();
    chk({tag, ".done"},      32'(done),   32'(1));
    chk({tag, ".s_done"},    32'(s_done), 32'(1));
    chk({tag, ".done_busy"}, 32'(busy),   32'(0));
    check_results({tag, ".final"});
    if (start_in_done) begin
      start   = 1'b1;
      win_len = 16'd2;
    end
    step();
    start = 1'b0;
    chk({tag, ".post_done"}, 32'(done), 32'(0));
    chk({tag, ".post_busy"}, 32'(busy), 32'(0));
    check_results({tag, ".hold"});
    step();
    chk({tag, ".post_busy2"}, 32'(busy), 32'(0));
    check_results({tag, ".hold2"});
  endtask

  initial begin
    logic [DW-1:0] ra, rb;
    int unsigned   len;

    rst = 1'b1; start = 1'b0; abort = 1'b0; valid = 1'b0;
    win_len = '0; A = '0; B = '0;
    model_clear();
    step(); step();
    rst = 1'b0;

    // Reset state
    chk("rst.busy", 32'(busy), 32'(0));
    chk("rst.done", 32'(done), 32'(0));
    check_stage1("rst");
    check_results("rst");

    // Single-word window
    open_window("t1", 16'd1);
    send_word("t1", 8'd8, 8'd7);
    chk("t1.mask", 32'(error), 32'(8'h0F));
    chk("t1.cnt",  32'(err_bits), 32'(4));
    finish_window("t1", 1'b0);

    // Three-word window including a matching pair and a negative value
    open_window("t2", 16'd3);
    send_word("t2", 8'd100, 8'd120);
    send_word("t2", 8'd250, 8'd250);
    chk("t2.zero_mask", 32'(error), 32'(0));
    send_word("t2", 8'd0, 8'hFB);
    chk("t2.mask3", 32'(error), 32'(8'hFB));
    finish_window("t2", 1'b0);

    // Saturation of the narrow accumulator
    open_window("t3", 16'd3);
    for (int i = 0; i < 3; i++) send_word("t3", 8'h00, 8'hFF);
    finish_window("t3", 1'b0);
    chk("t3.s_bits", 32'(s_bit_errs), 32'(15));
    chk("t3.s_sat",  32'(s_sat), 32'(1));
    chk("t3.bits",   32'(bit_errs), 32'(24));

    // Abort after four words; coincident valid word is dropped
    open_window("t4", 16'd10);
    for (int i = 0; i < 4; i++) send_word("t4", DW'($urandom), DW'($urandom));
    abort = 1'b1; valid = 1'b1; A = 8'h55; B = 8'hAA;
    step();
    abort = 1'b0; valid = 1'b0;
    chk("t4.busy", 32'(busy), 32'(0));
    chk("t4.done", 32'(done), 32'(0));
    check_stage1("t4");
    check_results("t4");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4.nodone", 32'(done | s_done), 32'(0));
      check_results("t4.hold");
    end

    // Ignored starts, valid in IDLE, abort in IDLE, start in DONE
    open_window("t5", 16'd3);
    send_word("t5", DW'($urandom), DW'($urandom));
    ra = DW'($urandom); rb = DW'($urandom);
    start = 1'b1; win_len = 16'd7; valid = 1'b1; A = ra; B = rb;
    step();
    start = 1'b0; valid = 1'b0;
    model_word(ra, rb);
    chk("t5.restart_busy", 32'(busy), 32'(1));
    check_stage1("t5.restart");
    chk("t5.restart_words", 32'(words), 32'(m_words));
    send_word("t5", DW'($urandom), DW'($urandom));
    finish_window("t5", 1'b0);
    start = 1'b1; win_len = '0;
    step();
    start = 1'b0;
    chk("t5.len0_busy", 32'(busy), 32'(0));
    check_results("t5.len0");
    valid = 1'b1; A = 8'h0F; B = 8'hF0;
    step();
    valid = 1'b0;
    check_stage1("t5.idle_valid");
    check_results("t5.idle_valid");
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_results("t5.idle_abort");
    open_window("t5b", 16'd2);
    send_word("t5b", DW'($urandom), DW'($urandom));
    send_word("t5b", DW'($urandom), DW'($urandom));
    finish_window("t5b", 1'b1);

    // Reset mid-window
    open_window("t6", 16'd5);
    send_word("t6", 8'h00, 8'hFF);
    send_word("t6", 8'h0F, 8'hFF);
    rst = 1'b1; valid = 1'b1; A = 8'h00; B = 8'hFF;
    step();
    rst = 1'b0; valid = 1'b0;
    model_clear();
    chk("t6.busy", 32'(busy), 32'(0));
    chk("t6.done", 32'(done), 32'(0));
    check_stage1("t6");
    check_results("t6");
    step();
    check_results("t6.settle");
    open_window("t6b", 16'd2);
    send_word("t6b", DW'($urandom), DW'($urandom));
    send_word("t6b", DW'($urandom), DW'($urandom));
    finish_window("t6b", 1'b0);

    // Random windows
    for (int w = 0; w < 6; w++) begin
      len = $urandom_range(1, 8);
      open_window("rnd", WW'(len));
      for (int unsigned i = 0; i < len; i++) begin
        ra = DW'($urandom);
        rb = ($urandom_range(0, 1) == 1) ? ~ra : DW'($urandom);
        send_word("rnd", ra, rb);
      end
      finish_window("rnd", 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
